// File: rtl/heart_bullet_collision.sv
// heart_bullet_collision
//   Detects heart/bullet sprite overlap during active video and maintains the
//   player's HP once per frame. A hit starts an invulnerability window during
//   which the heart blinks. HP reaching 0 latches the player dead until
//   restart or rst.
//
// Optional feature: define HP_REGEN_EN to regain 1 HP after REGEN_FRAMES
//   consecutive hit-free frames spent alive and not invulnerable.
//
// Ports
//   Pclk          in   pixel clock, sole clock
//   rst           in   synchronous reset, active-high
//   xx, yy        in   current raster position (frame ends at 639,479)
//   aactive       in   active video
//   HeartSpriteOn in   heart sprite flag
//   BulletOn      in   one flag per bullet sprite
//   restart       in   single-cycle pulse that revives the player
//   hp            out  current HP
//   hit_pulse     out  one-cycle pulse when damage is applied
//   invulnerable  out  high while in the invulnerability window
//   dead          out  high once HP has reached 0
//   HeartVisible  out  heart flag gated by blink and death, one cycle late
module heart_bullet_collision #(
    parameter int unsigned NBULLETS      = 4,
    parameter int unsigned HP_MAX        = 20,
    parameter int unsigned DAMAGE        = 4,
    parameter int unsigned INVULN_FRAMES = 30,
    parameter int unsigned BLINK_FRAMES  = 4,
    parameter int unsigned REGEN_FRAMES  = 120
) (
    input  logic                Pclk,
    input  logic                rst,
    input  logic [9:0]          xx,
    input  logic [9:0]          yy,
    input  logic                aactive,
    input  logic                HeartSpriteOn,
    input  logic [NBULLETS-1:0] BulletOn,
    input  logic                restart,
    output logic [7:0]          hp,
    output logic                hit_pulse,
    output logic                invulnerable,
    output logic                dead,
    output logic                HeartVisible
);

    localparam int unsigned HP_W    = 8;
    localparam int unsigned INV_W   = 8;
    localparam int unsigned BLINK_W = 4;
`ifdef HP_REGEN_EN
    localparam int unsigned REGEN_W = 10;
`endif

    localparam logic [9:0]      X_LAST     = 10'd639;
    localparam logic [9:0]      Y_LAST     = 10'd479;
    localparam logic [HP_W-1:0] HP_MAX_V   = HP_W'(HP_MAX);
    localparam logic [HP_W-1:0] DAMAGE_V   = HP_W'(DAMAGE);
    localparam logic [INV_W-1:0] INV_LOAD  = INV_W'(INVULN_FRAMES - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);
`ifdef HP_REGEN_EN
    localparam logic [REGEN_W-1:0] REGEN_LAST = REGEN_W'(REGEN_FRAMES - 1);
`endif

    typedef enum logic [1:0] {
        ALIVE  = 2'd0,
        INVULN = 2'd1,
        DEAD   = 2'd2
    } state_t;

    state_t               state;
    logic                 hit_pending;
    logic [INV_W-1:0]     inv_cnt;
    logic [BLINK_W-1:0]   blink_cnt;
    logic                 phase;
`ifdef HP_REGEN_EN
    logic [REGEN_W-1:0]   regen_cnt;
`endif

    logic                 overlap;
    logic                 frame_end;
    logic                 hit_frame;
    logic [HP_W-1:0]      hp_dmg;

    // Per-pixel collision and once-per-frame evaluation point
    assign overlap   = aactive & HeartSpriteOn & (|BulletOn);
    assign frame_end = (xx == X_LAST) && (yy == Y_LAST);
    // An overlap in the frame_end cycle itself belongs to the ending frame
    assign hit_frame = hit_pending | overlap;
    // Saturating damage: never wraps below zero
    assign hp_dmg    = (hp > DAMAGE_V) ? (hp - DAMAGE_V) : '0;

    // Player state machine, HP bookkeeping and registered outputs
    always_ff @(posedge Pclk) begin
        if (rst || restart) begin
            state        <= ALIVE;
            hp           <= HP_MAX_V;
            hit_pulse    <= 1'b0;
            invulnerable <= 1'b0;
            dead         <= 1'b0;
            HeartVisible <= 1'b0;
            hit_pending  <= 1'b0;
            inv_cnt      <= '0;
            blink_cnt    <= '0;
            phase        <= 1'b0;
`ifdef HP_REGEN_EN
            regen_cnt    <= '0;
`endif
        end else begin
            hit_pulse    <= 1'b0;
            // Uses the current (registered) window/phase/death state
            HeartVisible <= HeartSpriteOn & ~(invulnerable & phase) & ~dead;

            if (frame_end) begin
                hit_pending <= 1'b0;
                case (state)
                    ALIVE: begin
                        if (hit_frame) begin
                            hp        <= hp_dmg;
                            hit_pulse <= 1'b1;
                            blink_cnt <= '0;
                            phase     <= 1'b0;
`ifdef HP_REGEN_EN
                            regen_cnt <= '0;
`endif
                            if (hp_dmg == '0) begin
                                state <= DEAD;
                                dead  <= 1'b1;
                            end else begin
                                state        <= INVULN;
                                invulnerable <= 1'b1;
                                inv_cnt      <= INV_LOAD;
                            end
                        end
`ifdef HP_REGEN_EN
                        else if (regen_cnt == REGEN_LAST) begin
                            regen_cnt <= '0;
                            if (hp < HP_MAX_V) begin
                                hp <= hp + 8'd1;
                            end
                        end else begin
                            regen_cnt <= regen_cnt + 10'd1;
                        end
`endif
                    end

                    INVULN: begin
`ifdef HP_REGEN_EN
                        regen_cnt <= '0;
`endif
                        if (inv_cnt == '0) begin
                            state        <= ALIVE;
                            invulnerable <= 1'b0;
                            blink_cnt    <= '0;
                            phase        <= 1'b0;
                        end else begin
                            inv_cnt <= inv_cnt - 8'd1;
                            // Blink half-period counted in whole frames
                            if (blink_cnt == BLINK_LAST) begin
                                blink_cnt <= '0;
                                phase     <= ~phase;
                            end else begin
                                blink_cnt <= blink_cnt + 4'd1;
                            end
                        end
                    end

                    DEAD: begin
                        hp <= '0;
`ifdef HP_REGEN_EN
                        regen_cnt <= '0;
`endif
                    end

                    default: begin
                        state        <= ALIVE;
                        invulnerable <= 1'b0;
                        dead         <= 1'b0;
                    end
                endcase
            end else if (overlap) begin
                hit_pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_heart_bullet_collision.sv
// tb_heart_bullet_collision
//   Self-checking bench: compressed frames (eight cycles, the last at 639,479),
//   randomized sprite flags, and a frame-level HP/invulnerability model.
module tb_heart_bullet_collision;

    localparam int NB  = 4;
    localparam int HPM = 20;
    localparam int DMG = 4;
    localparam int INV = 30;
    localparam int BLK = 4;
    localparam int RGN = 120;

    logic          Pclk = 1'b0;
    logic          rst = 1'b0;
    logic [9:0]    xx = '0;
    logic [9:0]    yy = '0;
    logic          aactive = 1'b0;
    logic          HeartSpriteOn = 1'b0;
    logic [NB-1:0] BulletOn = '0;
    logic          restart = 1'b0;
    logic [7:0]    hp;
    logic          hit_pulse;
    logic          invulnerable;
    logic          dead;
    logic          HeartVisible;

    heart_bullet_collision #(
        .NBULLETS(NB), .HP_MAX(HPM), .DAMAGE(DMG),
        .INVULN_FRAMES(INV), .BLINK_FRAMES(BLK), .REGEN_FRAMES(RGN)
    ) dut (
        .Pclk(Pclk), .rst(rst), .xx(xx), .yy(yy), .aactive(aactive),
        .HeartSpriteOn(HeartSpriteOn), .BulletOn(BulletOn), .restart(restart),
        .hp(hp), .hit_pulse(hit_pulse), .invulnerable(invulnerable),
        .dead(dead), .HeartVisible(HeartVisible)
    );

    always #20 Pclk = ~Pclk;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;
    bit rnd_restart = 1'b0;
    bit force_restart = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: HP, frames of invulnerability left, frames since the hit
    int m_hp = HPM;
    int m_inv = 0;
    int m_el = 0;
    int m_regen = 0;
    bit m_pend = 1'b0;
    bit m_pulse = 1'b0;
    bit m_hv = 1'b0;

    initial begin : model
        bit ov, fe, hitf;
        forever begin
            @(posedge Pclk);
            ov = aactive && HeartSpriteOn && (BulletOn != '0);
            fe = (xx == 10'd639) && (yy == 10'd479);
            if (rst || restart) begin
                m_hp = HPM; m_inv = 0; m_el = 0; m_regen = 0;
                m_pend = 1'b0; m_pulse = 1'b0; m_hv = 1'b0;
            end else begin
                m_hv = HeartSpriteOn && !((m_inv > 0) && (((m_el / BLK) % 2) == 1)) && (m_hp != 0);
                m_pulse = 1'b0;
                if (fe) begin
                    hitf = m_pend || ov;
                    m_pend = 1'b0;
                    if (m_hp == 0) begin
                    end else if (m_inv > 0) begin
                        m_inv--;
                        m_el++;
                    end else if (hitf) begin
                        m_hp = (m_hp > DMG) ? m_hp - DMG : 0;
                        m_pulse = 1'b1;
                        m_regen = 0;
                        if (m_hp > 0) begin
                            m_inv = INV;
                            m_el = 0;
                        end
                    end
`ifdef HP_REGEN_EN
                    else begin
                        m_regen++;
                        if (m_regen == RGN) begin
                            m_regen = 0;
                            if (m_hp < HPM) m_hp++;
                        end
                    end
`endif
                end else if (ov) begin
                    m_pend = 1'b1;
                end
            end
        end
    end

    // Every-cycle comparison against the model
    initial begin : compare
        forever begin
            @(negedge Pclk);
            if (chk_en) begin
                check("hp", 32'(hp), 32'(m_hp));
                check("hit_pulse", 32'(hit_pulse), 32'(m_pulse));
                check("invulnerable", 32'(invulnerable), 32'(m_inv > 0));
                check("dead", 32'(dead), 32'(m_hp == 0));
                check("HeartVisible", 32'(HeartVisible), 32'(m_hv));
            end
        end
    end

    task automatic drive(input bit a, input bit h, input logic [NB-1:0] b, input bit fe);
        aactive = a;
        HeartSpriteOn = h;
        BulletOn = b;
        if (fe) begin
            xx = 10'd639;
            yy = 10'd479;
        end else begin
            xx = 10'($urandom_range(0, 638));
            yy = 10'($urandom_range(0, 479));
        end
        restart = force_restart || (rnd_restart && ($urandom_range(0, 1999) == 0));
        @(negedge Pclk);
    endtask

    // mode 0 none, 1 one mid-frame overlap, 2 random, 3 overlap with aactive=0,
    // 4 overlap only in frame_end cycle, 5 heart on + overlap every cycle
    task automatic gen(input int mode, input bit fe, input int idx,
                       output bit a, output bit h, output logic [NB-1:0] b);
        logic [NB-1:0] nz;
        nz = NB'($urandom_range(1, (1 << NB) - 1));
        a = 1'($urandom_range(0, 1));
        h = 1'($urandom_range(0, 1));
        b = NB'($urandom);
        case (mode)
            1: if (idx == 3) begin a = 1'b1; h = 1'b1; b = nz; end
            2: if ($urandom_range(0, 15) == 0) begin a = 1'b1; h = 1'b1; b = nz; end
            3: begin a = 1'b0; h = 1'b1; b = nz; end
            4: if (fe) begin a = 1'b1; h = 1'b1; b = nz; end
            5: begin a = 1'b1; h = 1'b1; b = nz; end
            default: ;
        endcase
        if (mode != 3 && mode != 5 && a && h && !(mode == 1 && idx == 3)
            && !(mode == 4 && fe) && !(mode == 2 && b == nz)) b = '0;
    endtask

    task automatic frame(input int mode, input int hv_exp);
        for (int i = 0; i < 8; i++) begin
            bit a, h;
            logic [NB-1:0] b;
            gen(mode, i == 7, i, a, h, b);
            drive(a, h, b, i == 7);
            if (i == 3 && hv_exp >= 0) check("blink_heart_visible", 32'(HeartVisible), 32'(hv_exp));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, '0, 1'b0);
        chk_en = 1'b1;
        drive(1'b0, 1'b0, '0, 1'b0);
        rst = 1'b0;
    endtask

    initial begin : stim
        do_reset();
        check("reset_hp", 32'(hp), 32'd20);
        check("reset_dead", 32'(dead), 32'd0);
        check("reset_invuln", 32'(invulnerable), 32'd0);
        check("reset_pulse", 32'(hit_pulse), 32'd0);
        check("reset_visible", 32'(HeartVisible), 32'd0);

        frame(0, -1);
        frame(0, -1);
        frame(1, -1);
        check("first_hit_hp", 32'(hp), 32'd16);
        check("first_hit_pulse", 32'(hit_pulse), 32'd1);
        check("first_hit_invuln", 32'(invulnerable), 32'd1);
        drive(1'b0, 1'b0, '0, 1'b0);
        check("pulse_one_cycle", 32'(hit_pulse), 32'd0);

        for (int k = 1; k <= 8; k++) frame(5, (k <= 4) ? 1 : 0);
        for (int k = 9; k <= 29; k++) frame(1, -1);
        check("invuln_frame29", 32'(invulnerable), 32'd1);
        check("invuln_hp_held", 32'(hp), 32'd16);
        frame(1, -1);
        check("invuln_ends_30", 32'(invulnerable), 32'd0);
        check("invuln_end_hp", 32'(hp), 32'd16);
        frame(1, -1);
        check("second_hit_hp", 32'(hp), 32'd12);

        for (int e = 8; e >= 0; e -= 4) begin
            for (int k = 0; k < 30; k++) frame(2, -1);
            check("spaced_hp_before", 32'(hp), 32'(e + 4));
            check("spaced_invuln_clear", 32'(invulnerable), 32'd0);
            frame(1, -1);
            check("spaced_hit_hp", 32'(hp), 32'(e));
        end
        check("dead_set", 32'(dead), 32'd1);
        for (int k = 0; k < 3; k++) frame(1, -1);
        check("dead_hp_held", 32'(hp), 32'd0);
        check("dead_no_pulse", 32'(hit_pulse), 32'd0);
        force_restart = 1'b1;
        drive(1'b0, 1'b0, '0, 1'b0);
        force_restart = 1'b0;
        check("restart_hp", 32'(hp), 32'd20);
        check("restart_dead", 32'(dead), 32'd0);

        frame(3, -1);
        check("inactive_no_hit", 32'(hp), 32'd20);
        frame(4, -1);
        check("frame_end_hit_hp", 32'(hp), 32'd16);
        check("frame_end_hit_pulse", 32'(hit_pulse), 32'd1);

`ifdef HP_REGEN_EN
        for (int k = 0; k < 30; k++) frame(0, -1);
        for (int k = 0; k < 119; k++) frame(0, -1);
        check("regen_not_yet", 32'(hp), 32'd16);
        frame(0, -1);
        check("regen_plus_one", 32'(hp), 32'd17);
`endif

        rnd_restart = 1'b1;
        for (int f = 0; f < 400; f++) begin
            int r;
            if (f % 97 == 50) do_reset();
            r = int'($urandom_range(0, 7));
            case (r)
                4: frame(0, -1);
                5: frame(1, -1);
                6: frame(3, -1);
                7: frame(4, -1);
                default: frame(2, -1);
            endcase
        end
        rnd_restart = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
